// File: rtl/mult_div_unit_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: op codes,
// default latencies and op-class helpers used by the controller and decode.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers. Results are
// computed at the start edge and committed when the latency counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        start,
  input  logic [3:0]  mudeop,
  output logic        busy,
  output logic [31:0] out
);

  // Sized for the longer of the two latencies so an oversized MULT_CYCLES cannot wrap.
  localparam int CNT_W = $clog2(max_int(DIV_CYCLES, MULT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [31:0]      hi, lo;
  logic [31:0]      pending_hi, pending_lo;
  logic [CNT_W-1:0] count;

  logic               accept;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_signed;
  logic [31:0]        a_mag, b_mag, uq, ur, quot, rem;
  logic [31:0]        res_hi, res_lo;

  assign busy   = (count != '0);
  assign accept = start && !busy && (is_mul_op(mudeop) || is_div_op(mudeop));

  assign prod_s = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
  assign prod_u = {32'd0, src1} * {32'd0, src2};

  // Signed division runs on magnitudes so truncation toward zero and the
  // 0x80000000 / -1 overflow fall out without relying on operator corner cases.
  always_comb begin
    div_signed = (mudeop == MD_DIV);
    a_mag = (div_signed && src1[31]) ? (32'd0 - src1) : src1;
    b_mag = (div_signed && src2[31]) ? (32'd0 - src2) : src2;
    uq = '0;
    ur = '0;
    if (b_mag != '0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    quot = (div_signed && (src1[31] ^ src2[31])) ? (32'd0 - uq) : uq;
    rem  = (div_signed && src1[31]) ? (32'd0 - ur) : ur;
  end

  // A zero divisor stages the current HI/LO so the later commit is a no-op.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (mudeop)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (src2 != '0) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi         <= '0;
      lo         <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      count      <= '0;
    end else if (busy) begin
      count <= count - 1'b1;
      if (count == CNT_W'(1)) begin
        hi <= pending_hi;
        lo <= pending_lo;
      end
    end else if (accept) begin
      pending_hi <= res_hi;
      pending_lo <= res_lo;
      count      <= is_mul_op(mudeop) ? MULT_LOAD : DIV_LOAD;
    end else if (mudeop == MD_MTHI) begin
      hi <= src1;
    end else if (mudeop == MD_MTLO) begin
      lo <= src1;
    end
  end

  always_comb begin
    out = '0;
    case (mudeop)
      MD_MFHI: out = hi;
      MD_MFLO: out = lo;
      default: out = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, arithmetic
// results, HI/LO moves, ignored starts and asynchronous reset abort.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] src1, src2;
  logic        start;
  logic [3:0]  mudeop;
  logic        busy;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .src1   (src1),
    .src2   (src2),
    .start  (start),
    .mudeop (mudeop),
    .busy   (busy),
    .out    (out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mudeop = op; src1 = a; src2 = b;
    step();
    start = 1'b0; mudeop = 4'd0; src1 = '0; src2 = '0;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    mudeop = op; src1 = a;
    step();
    mudeop = 4'd0; src1 = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      step();
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    mudeop = 4'd5; #1 h = out;
    mudeop = 4'd6; #1 l = out;
    mudeop = 4'd0; #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1'b1; start = 1'b0; mudeop = 4'd0; src1 = '0; src2 = '0;
    repeat (2) step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (out !== 32'd0) begin bad++; $display("FAIL reset_out_nop got=%h exp=0", out); end
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'd0) begin
      bad++; $display("FAIL reset_hilo got=%h_%h exp=0_0", h, l);
    end
    @(negedge clk); reset = 1'b0;
    step();
  endtask

  task automatic test_mult();
    int n;
    logic [31:0] h, l;
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    total++;
    if (n != 5) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
    read_hilo(h, l);
    total++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFA) begin
      bad++; $display("FAIL mult_result got=%h_%h exp=ffffffff_fffffffa", h, l);
    end
    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    total++;
    if (n != 5) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
    read_hilo(h, l);
    total++;
    if (h !== 32'h00000002 || l !== 32'hFFFFFFFA) begin
      bad++; $display("FAIL multu_result got=%h_%h exp=00000002_fffffffa", h, l);
    end
  endtask

  task automatic test_div();
    int n;
    logic [31:0] h, l;
    move_to(4'd7, 32'hAAAA5555);
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    mudeop = 4'd5; #1;
    total++;
    if (out !== 32'hAAAA5555) begin bad++; $display("FAIL div_mfhi_busy got=%h exp=aaaa5555", out); end
    mudeop = 4'd0;
    wait_idle(n);
    total++;
    if (n != 10) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
    read_hilo(h, l);
    total++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_neg_result got=%h_%h exp=ffffffff_fffffffd", h, l);
    end
    issue(4'd3, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    read_hilo(h, l);
    total++;
    if (h !== 32'd1 || l !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_negdivisor got=%h_%h exp=00000001_fffffffd", h, l);
    end
    issue(4'd4, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    read_hilo(h, l);
    total++;
    if (h !== 32'd1 || l !== 32'h7FFFFFFC) begin
      bad++; $display("FAIL divu_result got=%h_%h exp=00000001_7ffffffc", h, l);
    end
  endtask

  task automatic test_div_zero();
    int n;
    logic [31:0] h, l;
    move_to(4'd7, 32'h0BAD0BAD);
    move_to(4'd8, 32'h12345678);
    issue(4'd4, 32'd99, 32'd0);
    wait_idle(n);
    total++;
    if (n != 10) begin bad++; $display("FAIL divz_busy_cycles got=%0d exp=10", n); end
    read_hilo(h, l);
    total++;
    if (h !== 32'h0BAD0BAD || l !== 32'h12345678) begin
      bad++; $display("FAIL divz_retain got=%h_%h exp=0bad0bad_12345678", h, l);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] h, l;
    issue(4'd1, 32'd5, 32'd7);
    step();
    start = 1'b1; mudeop = 4'd3; src1 = 32'd100; src2 = 32'd3;
    step();
    start = 1'b0; mudeop = 4'd7; src1 = 32'hDEADBEEF; src2 = '0;
    step();
    mudeop = 4'd0; src1 = '0;
    wait_idle(n);
    total++;
    if (n + 3 != 5) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=5", n + 3); end
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'd35) begin
      bad++; $display("FAIL b2b_result got=%h_%h exp=00000000_00000023", h, l);
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] h, l;
    start = 1'b1; mudeop = 4'd6; src1 = 32'd1; src2 = 32'd1;
    step();
    start = 1'b1; mudeop = 4'd9;
    step();
    start = 1'b0; mudeop = 4'd0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bad_op_start got=%b exp=0", busy); end
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'd35) begin
      bad++; $display("FAIL bad_op_hilo got=%h_%h exp=00000000_00000023", h, l);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] h, l;
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) step();
    reset = 1'b1; #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'd0) begin
      bad++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", h, l);
    end
    @(negedge clk); reset = 1'b0;
    repeat (12) step();
    read_hilo(h, l);
    total++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      bad++; $display("FAIL rst_no_commit got=%b_%h_%h exp=0_0_0", busy, h, l);
    end
  endtask

  task automatic test_div_overflow();
    int n;
    logic [31:0] h, l;
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    total++;
    if (n != 10) begin bad++; $display("FAIL ovf_busy_cycles got=%0d exp=10", n); end
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'h80000000) begin
      bad++; $display("FAIL ovf_result got=%h_%h exp=00000000_80000000", h, l);
    end
    issue(4'd3, 32'd100, 32'd7);
    wait_idle(n);
    read_hilo(h, l);
    total++;
    if (h !== 32'd2 || l !== 32'd14) begin
      bad++; $display("FAIL div_pos_result got=%h_%h exp=00000002_0000000e", h, l);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_div_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
